// File: rtl/mas_stream_pkg.sv
// Shared encodings and FSM state type for the mas_stream modular accumulator.
package mas_stream_pkg;

  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b11;

  localparam logic [1:0] TC_UNDER = 2'b00;
  localparam logic [1:0] TC_IN    = 2'b01;
  localparam logic [1:0] TC_OVER  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mas_stream_if.sv
// Operand and result handshake bundle for mas_stream.
interface mas_stream_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_din;
  logic [1:0]       in_sel;
  logic [W-1:0]     in_q;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_dout;
  logic [1:0]       out_tcmp;
  logic [CNT_W-1:0] out_wraps;
  logic             out_err;

  modport master (
    output in_valid, in_din, in_sel, in_q, in_last, out_ready,
    input  in_ready, out_valid, out_dout, out_tcmp, out_wraps, out_err
  );

  modport slave (
    input  in_valid, in_din, in_sel, in_q, in_last, out_ready,
    output in_ready, out_valid, out_dout, out_tcmp, out_wraps, out_err
  );

endinterface

// File: rtl/mas_step.sv
// Per-beat modular add/subtract with a single correction step toward 0..q-1.
module mas_step
  import mas_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] din_i,
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] next_acc_o,
  output logic [1:0]   tcmp_o,
  output logic         err_o
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] ZERO = '0;

  logic signed [SW-1:0] acc_s;
  logic signed [SW-1:0] din_s;
  logic signed [SW-1:0] q_s;
  logic signed [SW-1:0] tmp_s;

  always_comb begin
    acc_s = signed'({2'b00, acc_i});
    din_s = signed'({2'b00, din_i});
    q_s   = signed'({2'b00, q_i});

    case (sel_i)
      SEL_ADD: tmp_s = acc_s + din_s;
      SEL_SUB: tmp_s = acc_s - din_s;
      default: tmp_s = acc_s;
    endcase

    tcmp_o = {tmp_s >= q_s, tmp_s >= ZERO};

    // The corrected value always fits in W bits, so the low W bits suffice.
    case (tcmp_o)
      TC_UNDER: next_acc_o = tmp_s[W-1:0] + q_i;
      TC_OVER:  next_acc_o = tmp_s[W-1:0] - q_i;
      default:  next_acc_o = tmp_s[W-1:0];
    endcase

    err_o = (q_i == '0) || (din_i >= q_i);
  end

endmodule

// File: rtl/mas_stream.sv
// Streaming modular add/sub accumulator: folds a group of beats into one residue mod Q.
module mas_stream
  import mas_stream_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  mas_stream_if.slave  bus
);

  localparam logic [CNT_W-1:0] WR_MAX = '1;

  state_e           state_q, state_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [1:0]       tc_q, tc_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic             err_q, err_d;

  logic             first;
  logic             accept;
  logic [W-1:0]     step_q;
  logic [W-1:0]     step_acc;
  logic [1:0]       step_tc;
  logic             step_err;

  assign first        = (state_q == IDLE);
  assign bus.in_ready = !rst && (state_q != OUT);
  assign accept       = bus.in_valid && bus.in_ready;
  // The modulus is taken from the bus only on the opening beat of a group.
  assign step_q       = first ? bus.in_q : q_q;

  mas_step #(.W(W)) u_step (
    .acc_i      (acc_q),
    .din_i      (bus.in_din),
    .sel_i      (bus.in_sel),
    .q_i        (step_q),
    .next_acc_o (step_acc),
    .tcmp_o     (step_tc),
    .err_o      (step_err)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    acc_d   = acc_q;
    tc_d    = tc_q;
    wr_d    = wr_q;
    err_d   = err_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (first) q_d = bus.in_q;
          if (step_err) begin
            err_d = 1'b1;
          end else begin
            acc_d = step_acc;
            tc_d  = step_tc;
            if (step_tc != TC_IN && wr_q != WR_MAX) wr_d = wr_q + 1'b1;
          end
          state_d = bus.in_last ? OUT : ACC;
        end
      end
      OUT: begin
        // Group state is cleared here so IDLE always starts from zero.
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          tc_d    = TC_IN;
          wr_d    = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tc_q    <= TC_IN;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tc_q    <= tc_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
    q_q <= q_d;
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.out_dout  = acc_q;
  assign bus.out_tcmp  = tc_q;
  assign bus.out_wraps = wr_q;
  assign bus.out_err   = err_q;

endmodule

// File: doc/mas_stream.md
Name: mas_stream

Overview:
- Streaming modular add/subtract accumulator: folds a variable-length group of operands into one residue mod Q.
- Each accepted operand applies add, subtract or skip to a running accumulator, then a single-step modular correction.
- Successor to the 2-input combinational modular add/sub: parametrised width, sequential, valid/ready on both sides, wrap counting and operand error detection.

Parameters:
- W, 4, operand / modulus / result width (unsigned, values 0..2^W-1).
- CNT_W, 4, width of the per-group wrap counter (saturating).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_din  input  W  operand, legal range 0..Q-1.
- in_sel  input  2  00 add, 11 subtract, 01/10 skip (accumulator unchanged).
- in_q  input  W  modulus, sampled on the first beat of a group only; must be >= 1.
- in_last  input  1  marks the final beat of a group.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_dout  output  W  final residue, 0..Q-1.
- out_tcmp  output  2  correction class of the last beat: 00 underflow (+Q), 01 in range, 11 overflow (-Q).
- out_wraps  output  CNT_W  number of beats in the group needing correction, saturates at all-ones.
- out_err  output  1  at least one beat in the group had in_din >= Q, or Q == 0.

Behaviour:
- Reset values: in_ready=0 during reset, 1 on the first cycle after. out_valid=0, out_dout=0, out_tcmp=01, out_wraps=0, out_err=0. State returns to IDLE.
- Reset mid-group discards the group. Reset while out_valid=1 drops the result.
- A beat is accepted when in_valid & in_ready.
- States:
  - IDLE: in_ready=1. An accepted beat latches q_r=in_q, treats acc as 0, applies the op, then goes to ACC, or to OUT if in_last.
  - ACC: in_ready=1. An accepted beat applies the op using q_r; in_q is ignored. in_last moves to OUT.
  - OUT: in_ready=0, out_valid=1, outputs stable. When out_ready=1, go to IDLE next cycle and clear the group state.
- Latency: the in_last beat accepted at cycle t gives out_valid=1 at t+1.
- Each beat is accepted only while the state is IDLE or ACC. No beat is accepted in the cycle a result is consumed, so there is one bubble per group.
- Arithmetic, per beat, in signed W+2 bits:
  - tmp = acc+din (00), acc-din (11), acc (01/10).
  - tcmp = {tmp>=q, tmp>=0}.
  - next acc = tmp+q (00), tmp (01), tmp-q (11).
  - With acc, din < q a single correction always lands in 0..q-1.
- Skip beats: tcmp=01, no wrap increment.
- Wrap counter increments on any beat with tcmp != 01 and saturates at 2^CNT_W-1.
- Error beat (din >= q_r, or a first beat with in_q == 0):
  - The beat is accepted but the accumulator is left unchanged.
  - Error is sticky for the group. in_last on an error beat still ends the group.
  - If Q == 0 the group result is out_dout=0.
- Single-beat group (first beat with in_last) is legal: the result is din mod-op from 0, e.g. 11 with din=5, Q=13 gives 8.
- out_tcmp reports the last non-error beat of the group, or 01 if there is none.

Decomposition:
- Shared package holds:
  - Sel encodings SEL_ADD=2'b00, SEL_SUB=2'b11.
  - Tcmp encodings TC_UNDER=2'b00, TC_IN=2'b01, TC_OVER=2'b11.
  - The state enum IDLE/ACC/OUT.
- One natural combinational sub-module, mas_step. Inputs: acc, din, sel, q. Outputs: next_acc, tcmp, err. It is the per-beat add/sub and modular-correction datapath.
- The top holds the FSM, q_r, the counters and the output registers.

Test Plan:
- W=4, Q=13, beats (00,7),(00,9,last) -> out_dout=3, out_tcmp=11, out_wraps=1, out_err=0, out_valid one cycle after the last beat.
- Q=13, beats (00,2),(11,5,last) -> out_dout=10, out_tcmp=00, out_wraps=1. Single beat (11,5,last) -> out_dout=8.
- Q=13, beats (00,4),(01,9),(10,9),(00,3,last) -> out_dout=7, out_wraps=0, out_tcmp=01. Change in_q to 5 on beat 2 -> result unchanged (Q latched).
- Q=13, beats (00,6),(00,14),(00,2,last) -> out_err=1, out_dout=8. The next clean group (00,1,last) -> out_err=0, out_dout=1.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and all outputs stable, in_ready=0. Release -> the next group is accepted the cycle after the handshake.
- Assert rst mid-group after 2 beats -> all outputs at reset values. A new group (00,3,last) -> out_dout=3, out_wraps=0.
